// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer slice.
// Time values are DIGITS packed BCD digits, digit 0 in bits [3:0].
package stopwatch_pkg;

  localparam int DIGITS = 6;
  localparam int TIME_W = DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // The Start button toggles between RUN and PAUSE, and leaves IDLE into RUN.
  function automatic sw_state_t start_next(sw_state_t cur);
    case (cur)
      IDLE:    return RUN;
      RUN:     return PAUSE;
      PAUSE:   return RUN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Board-side bundle of the stopwatch sequencer: raw buttons and live time in,
// counter controls, display time and status out.
interface stopwatch_if
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = 4
) ();

  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic              fStart;
  logic              fStop;
  logic              fRecord;
  logic [TIME_W-1:0] i_Time;
  logic              o_CntEn;
  logic              o_CntClr;
  logic [TIME_W-1:0] o_DispTime;
  logic [1:0]        o_State;
  logic [CNT_W-1:0]  o_LapCnt;
  logic              o_LapFull;

  modport master (
    output fStart, fStop, fRecord, i_Time,
    input  o_CntEn, o_CntClr, o_DispTime, o_State, o_LapCnt, o_LapFull
  );

  modport slave (
    input  fStart, fStop, fRecord, i_Time,
    output o_CntEn, o_CntClr, o_DispTime, o_State, o_LapCnt, o_LapFull
  );

endinterface

// File: rtl/sw_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debounce and a
// single-cycle press pulse on the debounced 1->0 edge (buttons are active-low).
module sw_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b1;
      sync_2  <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_1  <= raw_n;
      sync_2  <= sync_1;
      level_q <= level;
      press   <= level_q & ~level;
      // Any return to the accepted level restarts the stability count.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive the IDLE/RUN/PAUSE FSM, the lap
// buffer and the display mux. Define LAP_HOLD_EN to freeze the display on each lap.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES  = 500_000,
  parameter int LAP_DEPTH   = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic        Clk,
  input  logic        Rst,
  stopwatch_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(LAP_DEPTH + 1);
  localparam int                 IDX_W    = $clog2(LAP_DEPTH);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(LAP_DEPTH);

  logic start_ev;
  logic stop_ev;
  logic rec_ev;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(Clk), .rst_n(Rst), .raw_n(bus.fStart), .press(start_ev)
  );
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk(Clk), .rst_n(Rst), .raw_n(bus.fStop), .press(stop_ev)
  );
  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_record (
    .clk(Clk), .rst_n(Rst), .raw_n(bus.fRecord), .press(rec_ev)
  );

  sw_state_t         state;
  logic [TIME_W-1:0] lap [LAP_DEPTH];
  logic [CNT_W-1:0]  lap_cnt;
  logic [IDX_W-1:0]  rec_idx;
  logic              rec_act;
  logic              cnt_en;
  logic              cnt_clr;
  logic [TIME_W-1:0] disp;

`ifdef LAP_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic [TIME_W-1:0] hold_val;
`else
  logic unused_hold;
  assign unused_hold = (HOLD_CYCLES != 0);
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      lap_cnt <= '0;
      rec_idx <= '0;
      rec_act <= 1'b0;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
      disp    <= '0;
      // NOTE: the lap entries are reset (and wiped on Stop) so a recall can
      // never expose data captured before the last clear.
      for (int i = 0; i < LAP_DEPTH; i++) lap[i] <= '0;
`ifdef LAP_HOLD_EN
      hold_cnt <= '0;
      hold_val <= '0;
`endif
    end else begin
      // NOTE: all state here uses <=, so every right-hand side sees the
      // pre-edge values and later assignments override the defaults below.
      cnt_clr <= 1'b0;
      cnt_en  <= (state == RUN);
`ifdef LAP_HOLD_EN
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
`endif

      // Event priority Stop > Start > Record; losers are dropped.
      if (stop_ev) begin
        state   <= IDLE;
        cnt_clr <= 1'b1;
        lap_cnt <= '0;
        rec_idx <= '0;
        rec_act <= 1'b0;
        for (int i = 0; i < LAP_DEPTH; i++) lap[i] <= '0;
`ifdef LAP_HOLD_EN
        hold_cnt <= '0;
`endif
      end else if (start_ev) begin
        state   <= start_next(state);
        rec_idx <= '0;
        rec_act <= 1'b0;
`ifdef LAP_HOLD_EN
        hold_cnt <= '0;
`endif
      end else if (rec_ev) begin
        if (state == RUN) begin
          if (lap_cnt != FULL_CNT) begin
            lap[lap_cnt[IDX_W-1:0]] <= bus.i_Time;
            lap_cnt                 <= lap_cnt + CNT_W'(1);
`ifdef LAP_HOLD_EN
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
            hold_val <= bus.i_Time;
`endif
          end
        end else if (lap_cnt != '0) begin
          // Recall walks lap 0..LapCnt-1, then drops back to the live time.
          if (!rec_act) begin
            rec_act <= 1'b1;
            rec_idx <= '0;
          end else if (CNT_W'(rec_idx) == lap_cnt - CNT_W'(1)) begin
            rec_act <= 1'b0;
          end else begin
            rec_idx <= rec_idx + IDX_W'(1);
          end
        end
      end

`ifdef LAP_HOLD_EN
      if (hold_cnt != '0)  disp <= hold_val;
      else if (rec_act)    disp <= lap[rec_idx];
      else                 disp <= bus.i_Time;
`else
      if (rec_act)         disp <= lap[rec_idx];
      else                 disp <= bus.i_Time;
`endif
    end
  end

  assign bus.o_State    = state;
  assign bus.o_CntEn    = cnt_en;
  assign bus.o_CntClr   = cnt_clr;
  assign bus.o_DispTime = disp;
  assign bus.o_LapCnt   = lap_cnt;
  assign bus.o_LapFull  = (lap_cnt == FULL_CNT);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (DEB_CYCLES=4, LAP_DEPTH=4, HOLD_CYCLES=8).
// Define LAP_HOLD_EN for both DUT and bench to exercise the lap-hold display.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int DEB  = 4;
  localparam int LAPD = 4;
  localparam int HOLD = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #10 Clk = ~Clk;

  stopwatch_if #(.LAP_DEPTH(LAPD)) bus ();

  stopwatch_ctrl #(
    .DEB_CYCLES (DEB),
    .LAP_DEPTH  (LAPD),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the selected buttons (bit0 Start, bit1 Stop, bit2 Record) low for 20
  // cycles, release for 20, counting state changes and clear pulses.
  task automatic press(input logic [2:0] btns, input bit chk_en,
                       output int n_chg, output int n_clr);
    logic [1:0] prev;
    n_chg = 0;
    n_clr = 0;
    @(negedge Clk);
    prev        = bus.o_State;
    bus.fStart  = ~btns[0];
    bus.fStop   = ~btns[1];
    bus.fRecord = ~btns[2];
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (i == 20) begin
        bus.fStart  = 1'b1;
        bus.fStop   = 1'b1;
        bus.fRecord = 1'b1;
      end
      if (chk_en) check("cnt_en_lags_state", {31'd0, bus.o_CntEn}, {31'd0, prev == 2'd1});
      if (bus.o_State !== prev) n_chg++;
      if (bus.o_CntClr === 1'b1) n_clr++;
      prev = bus.o_State;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int chg;
    int clr;
    int found;
    logic [23:0] lap_vals [5];
    logic [1:0]  exp_st   [3];
    lap_vals = '{24'h000011, 24'h000022, 24'h000033, 24'h000044, 24'h000055};
    exp_st   = '{2'd1, 2'd2, 2'd1};

    bus.fStart  = 1'b1;
    bus.fStop   = 1'b1;
    bus.fRecord = 1'b1;
    bus.i_Time  = 24'h000000;

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_state",   32'(bus.o_State),    32'd0);
    check("rst_cnten",   32'(bus.o_CntEn),    32'd0);
    check("rst_cntclr",  32'(bus.o_CntClr),   32'd0);
    check("rst_lapcnt",  32'(bus.o_LapCnt),   32'd0);
    check("rst_lapfull", 32'(bus.o_LapFull),  32'd0);
    check("rst_disp",    32'(bus.o_DispTime), 32'd0);
    Rst = 1'b1;

    // Start x3: IDLE->RUN->PAUSE->RUN, CntEn trails State by one cycle
    for (int k = 0; k < 3; k++) begin
      press(3'b001, 1'b1, chg, clr);
      check("start_seq_state", 32'(bus.o_State), 32'(exp_st[k]));
      check("start_seq_chg",   32'(chg),         32'd1);
    end

    // Asynchronous reset in RUN with one lap stored
    bus.i_Time = 24'h000042;
    press(3'b100, 1'b0, chg, clr);
    check("pre_rst_lapcnt", 32'(bus.o_LapCnt),   32'd1);
    check("run_disp_live",  32'(bus.o_DispTime), 32'h000042);
    @(negedge Clk);
    #3 Rst = 1'b0;
    #1;
    check("async_rst_state",  32'(bus.o_State),    32'd0);
    check("async_rst_cnten",  32'(bus.o_CntEn),    32'd0);
    check("async_rst_lapcnt", 32'(bus.o_LapCnt),   32'd0);
    check("async_rst_disp",   32'(bus.o_DispTime), 32'd0);
    @(negedge Clk);
    Rst        = 1'b1;
    bus.i_Time = 24'h000000;

    // Bouncing Start: 2-cycle toggles never settle, then a steady press
    chg = 0;
    begin
      logic [1:0] prev;
      @(negedge Clk);
      prev = bus.o_State;
      for (int i = 0; i < 50; i++) begin
        bus.fStart = (i < 10) ? i[1] : (i >= 30);
        @(negedge Clk);
        if (bus.o_State !== prev) chg++;
        prev = bus.o_State;
      end
      bus.fStart = 1'b1;
    end
    check("bounce_events", 32'(chg),         32'd1);
    check("bounce_state",  32'(bus.o_State), 32'd1);

    // Two laps, then Stop
    bus.i_Time = 24'h000123;
    press(3'b100, 1'b0, chg, clr);
    check("lap1_cnt", 32'(bus.o_LapCnt), 32'd1);
    bus.i_Time = 24'h000456;
    press(3'b100, 1'b0, chg, clr);
    check("lap2_cnt",  32'(bus.o_LapCnt),  32'd2);
    check("lap2_full", 32'(bus.o_LapFull), 32'd0);
    press(3'b010, 1'b0, chg, clr);
    check("stop_clr_pulses", 32'(clr),            32'd1);
    check("stop_state",      32'(bus.o_State),    32'd0);
    check("stop_lapcnt",     32'(bus.o_LapCnt),   32'd0);

    // Record with no laps stored does nothing
    bus.i_Time = 24'h000777;
    press(3'b100, 1'b0, chg, clr);
    check("rec_empty_chg",  32'(chg),            32'd0);
    check("rec_empty_cnt",  32'(bus.o_LapCnt),   32'd0);
    check("rec_empty_disp", 32'(bus.o_DispTime), 32'h000777);

    // Fill the buffer; fifth capture is dropped
    press(3'b001, 1'b0, chg, clr);
    check("fill_run", 32'(bus.o_State), 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus.i_Time = lap_vals[k];
      press(3'b100, 1'b0, chg, clr);
      check("fill_lapcnt", 32'(bus.o_LapCnt), (k < 4) ? 32'(k + 1) : 32'd4);
    end
    check("fill_full", 32'(bus.o_LapFull), 32'd1);

    // Pause and recall lap0..lap3, then live
    press(3'b001, 1'b0, chg, clr);
    check("recall_pause", 32'(bus.o_State), 32'd2);
    bus.i_Time = 24'h999999;
    @(negedge Clk);
    check("recall_live0", 32'(bus.o_DispTime), 32'h999999);
    for (int k = 0; k < 5; k++) begin
      press(3'b100, 1'b0, chg, clr);
      check("recall_disp", 32'(bus.o_DispTime), (k < 4) ? 32'(lap_vals[k]) : 32'h999999);
    end
    check("recall_lapcnt", 32'(bus.o_LapCnt), 32'd4);

    // Entering RUN leaves recall
    press(3'b100, 1'b0, chg, clr);
    check("recall_again", 32'(bus.o_DispTime), 32'h000011);
    press(3'b001, 1'b0, chg, clr);
    check("resume_state", 32'(bus.o_State),    32'd1);
    check("resume_live",  32'(bus.o_DispTime), 32'h999999);

    // Same-cycle Start+Stop: Stop wins
    press(3'b011, 1'b0, chg, clr);
    check("both_chg",     32'(chg),            32'd1);
    check("both_clr",     32'(clr),            32'd1);
    check("both_state",   32'(bus.o_State),    32'd0);
    check("both_lapcnt",  32'(bus.o_LapCnt),   32'd0);
    check("both_lapfull", 32'(bus.o_LapFull),  32'd0);

`ifdef LAP_HOLD_EN
    // Lap hold: display frozen on the capture for HOLD cycles after the push
    press(3'b001, 1'b0, chg, clr);
    bus.i_Time = 24'h000777;
    @(negedge Clk);
    bus.fRecord = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge Clk);
      if (bus.o_LapCnt == 3'd1) found = 1;
    end
    check("hold_push_seen", 32'(found), 32'd1);
    bus.i_Time = 24'h000888;
    for (int j = 1; j <= HOLD + 1; j++) begin
      @(negedge Clk);
      if (j == 1)        check("hold_first", 32'(bus.o_DispTime), 32'h000777);
      if (j == HOLD)     check("hold_last",  32'(bus.o_DispTime), 32'h000777);
      if (j == HOLD + 1) check("hold_done",  32'(bus.o_DispTime), 32'h000888);
    end
    bus.fRecord = 1'b1;
    repeat (20) @(negedge Clk);
`else
    found = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
